// File: rtl/tx_packet_arbiter.sv
// Round-robin arbiter sharing the avr_interface TX packet port between two requesters.
// Streams the winner's words, commits the packet, then holds the grant until transmission ends.
module tx_packet_arbiter #(
    parameter int WORD_W       = 16,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic [1:0]        i_Req,
    input  logic [3:0]        i_Req_Cnt0,
    input  logic [3:0]        i_Req_Cnt1,
    input  logic [3:0]        i_Req_Type0,
    input  logic [3:0]        i_Req_Type1,
    input  logic [WORD_W-1:0] i_Req_Word0,
    input  logic [WORD_W-1:0] i_Req_Word1,
    output logic [1:0]        o_Grant,
    output logic [3:0]        o_Word_Idx,
    output logic [1:0]        o_Done,
    output logic [1:0]        o_Err,
    output logic [WORD_W-1:0] o_Tx_Word,
    output logic              o_Write_Tx_Word,
    output logic              o_New_Tx_DV,
    output logic [3:0]        o_Tx_Word_Cnt,
    output logic [3:0]        o_Tx_Resp_Type,
    input  logic              i_Tx_Busy
);

    localparam int TW = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LIMIT = TW'(BUSY_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_COMMIT,
        S_WAIT_BUSY,
        S_WAIT_IDLE,
        S_FINISH
    } state_t;

    state_t          state_reg, state_next;
    logic [1:0]      grant_reg, grant_next;
    logic            last_reg,  last_next;
    logic [3:0]      cnt_reg,   cnt_next;
    logic [3:0]      type_reg,  type_next;
    logic [3:0]      idx_reg,   idx_next;
    logic [TW-1:0]   tmo_reg,   tmo_next;
    logic            err_reg,   err_next;
    logic            winner;
    logic [TW-1:0]   tmo_inc;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_reg <= S_IDLE;
            grant_reg <= 2'b00;
            last_reg  <= 1'b1;
            cnt_reg   <= 4'd0;
            type_reg  <= 4'd0;
            idx_reg   <= 4'd0;
            tmo_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            last_reg  <= last_next;
            cnt_reg   <= cnt_next;
            type_reg  <= type_next;
            idx_reg   <= idx_next;
            tmo_reg   <= tmo_next;
            err_reg   <= err_next;
        end
    end

    // With both requesting, the requester not served last wins; a lone request wins outright.
    assign winner  = (i_Req == 2'b11) ? ~last_reg : i_Req[1];
    assign tmo_inc = tmo_reg + TW'(1);

    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        last_next       = last_reg;
        cnt_next        = cnt_reg;
        type_next       = type_reg;
        idx_next        = idx_reg;
        tmo_next        = tmo_reg;
        err_next        = err_reg;
        o_Write_Tx_Word = 1'b0;
        o_New_Tx_DV     = 1'b0;
        case (state_reg)
            S_IDLE: begin
                idx_next = 4'd0;
                err_next = 1'b0;
                if (!i_Tx_Busy && (i_Req != 2'b00)) begin
                    grant_next = winner ? 2'b10 : 2'b01;
                    cnt_next   = winner ? i_Req_Cnt1  : i_Req_Cnt0;
                    type_next  = winner ? i_Req_Type1 : i_Req_Type0;
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                if (cnt_reg == 4'd0) begin
                    err_next   = 1'b1;
                    state_next = S_FINISH;
                end else begin
                    o_Write_Tx_Word = 1'b1;
                    if (idx_reg == cnt_reg - 4'd1) begin
                        idx_next   = 4'd0;
                        state_next = S_COMMIT;
                    end else begin
                        idx_next = idx_reg + 4'd1;
                    end
                end
            end
            S_COMMIT: begin
                o_New_Tx_DV = 1'b1;
                tmo_next    = '0;
                state_next  = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (i_Tx_Busy) begin
                    state_next = S_WAIT_IDLE;
                end else begin
                    tmo_next = tmo_inc;
                    if (tmo_inc == TMO_LIMIT) begin
                        err_next   = 1'b1;
                        state_next = S_FINISH;
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (!i_Tx_Busy) state_next = S_FINISH;
            end
            S_FINISH: begin
                last_next  = grant_reg[1];
                grant_next = 2'b00;
                err_next   = 1'b0;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_done
            assign o_Done[gi] = (state_reg == S_FINISH) && grant_reg[gi];
            assign o_Err[gi]  = o_Done[gi] && err_reg;
        end
    endgenerate

    assign o_Grant        = grant_reg;
    assign o_Word_Idx     = idx_reg;
    assign o_Tx_Word      = grant_reg[1] ? i_Req_Word1 : (grant_reg[0] ? i_Req_Word0 : '0);
    assign o_Tx_Word_Cnt  = (state_reg == S_COMMIT) ? cnt_reg  : 4'd0;
    assign o_Tx_Resp_Type = (state_reg == S_COMMIT) ? type_reg : 4'd0;

endmodule

// File: tb/tb_tx_packet_arbiter.sv
// Randomized bench for tx_packet_arbiter: a timeline model predicts every output per cycle
// from the arbitration rules and the busy waveform the bench itself plans.
module tb_tx_packet_arbiter;

    localparam int NCYC = 2500;
    localparam int ASZ  = NCYC + 400;
    localparam int TMO  = 16;
    localparam int BIG  = 1 << 30;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [3:0]  cnt  [2];
    logic [3:0]  typ  [2];
    logic [15:0] base [2];
    logic        busy;
    logic [15:0] word0, word1;
    logic [1:0]  grant, done, err;
    logic [3:0]  widx, tx_cnt, tx_type;
    logic [15:0] tx_word;
    logic        wr, dv;

    bit [1:0]  exp_grant [ASZ];
    bit [1:0]  exp_done  [ASZ];
    bit [1:0]  exp_err   [ASZ];
    bit        exp_wr    [ASZ];
    bit        exp_dv    [ASZ];
    bit        busy_wave [ASZ];
    bit [3:0]  exp_idx   [ASZ];
    bit [3:0]  exp_cnt   [ASZ];
    bit [3:0]  exp_type  [ASZ];
    bit [15:0] exp_word  [ASZ];

    int n_cmp = 0;
    int n_bad = 0;
    int cur_t = 0;

    always #10 clk = ~clk;

    assign word0 = base[0] + {12'h000, widx};
    assign word1 = base[1] + {12'h000, widx};

    tx_packet_arbiter #(.WORD_W(16), .BUSY_TIMEOUT(TMO)) dut (
        .i_Clk           (clk),
        .i_Rst           (rst),
        .i_Req           (req),
        .i_Req_Cnt0      (cnt[0]),
        .i_Req_Cnt1      (cnt[1]),
        .i_Req_Type0     (typ[0]),
        .i_Req_Type1     (typ[1]),
        .i_Req_Word0     (word0),
        .i_Req_Word1     (word1),
        .o_Grant         (grant),
        .o_Word_Idx      (widx),
        .o_Done          (done),
        .o_Err           (err),
        .o_Tx_Word       (tx_word),
        .o_Write_Tx_Word (wr),
        .o_New_Tx_DV     (dv),
        .o_Tx_Word_Cnt   (tx_cnt),
        .o_Tx_Resp_Type  (tx_type),
        .i_Tx_Busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0d got=%h exp=%h", tag, cur_t, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_grant"}, 32'(grant), 32'd0);
        check({tag, "_wr"},    32'(wr),    32'd0);
        check({tag, "_idx"},   32'(widx),  32'd0);
        check({tag, "_dv"},    32'(dv),    32'd0);
        check({tag, "_done"},  32'(done),  32'd0);
        check({tag, "_err"},   32'(err),   32'd0);
        check({tag, "_word"},  32'(tx_word), 32'd0);
    endtask

    initial begin
        int hold_until [2];
        int free_at, last_srv, n_txn;
        int r, c, d, len, cmt, fin;
        bit terr;

        rst = 1'b1; req = 2'b00; busy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cnt[i] = 4'd0; typ[i] = 4'd0; base[i] = 16'h0000; hold_until[i] = BIG;
        end
        free_at = 0; last_srv = 1; n_txn = 0;

        // Reset holds everything at zero even with both requests present.
        repeat (2) @(posedge clk);
        #1 req = 2'b11; cnt[0] = 4'd2; cnt[1] = 4'd2;
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk);
        #1 rst = 1'b0; req = 2'b00;

        for (int t = 0; (t < NCYC) || (t < free_at + 10); t++) begin
            cur_t = t;
            for (int q = 0; q < 2; q++) begin
                if (req[q] && t > hold_until[q]) begin
                    if (t < NCYC && $urandom_range(0, 1) == 0) hold_until[q] = BIG;
                    else req[q] = 1'b0;
                end else if (!req[q] && t < NCYC && $urandom_range(0, 5) == 0) begin
                    req[q]        = 1'b1;
                    hold_until[q] = BIG;
                    cnt[q]  = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 6));
                    typ[q]  = 4'($urandom);
                    base[q] = 16'($urandom);
                end
            end

            if (t >= free_at && !busy_wave[t] && t < NCYC && $urandom_range(0, 9) == 0) begin
                len = $urandom_range(1, 4);
                for (int j = t; j < t + len; j++) busy_wave[j] = 1'b1;
            end

            if (t >= free_at && !busy_wave[t] && req != 2'b00) begin
                r = (req == 2'b11) ? ((last_srv == 0) ? 1 : 0) : (req[1] ? 1 : 0);
                c = int'(cnt[r]);
                cmt = t + 1 + c;
                if (c == 0) begin
                    terr = 1'b1;
                    fin  = t + 2;
                end else begin
                    if ($urandom_range(0, 4) == 0) begin
                        d = TMO + $urandom_range(0, 1);
                        terr = 1'b1;
                    end else begin
                        d = $urandom_range(0, 5);
                        terr = 1'b0;
                    end
                    len = $urandom_range(1, 6);
                    for (int j = cmt + 1 + d; j <= cmt + d + len; j++) busy_wave[j] = 1'b1;
                    fin = terr ? (cmt + 1 + TMO) : (cmt + 2 + d + len);
                    if ($urandom_range(0, 3) == 0) busy_wave[t + 1] = 1'b1;
                    exp_dv[cmt]   = 1'b1;
                    exp_cnt[cmt]  = 4'(c);
                    exp_type[cmt] = typ[r];
                end
                for (int j = t + 1; j <= fin; j++) begin
                    exp_grant[j] = 2'(1 << r);
                    exp_word[j]  = base[r];
                end
                for (int k = 0; k < c; k++) begin
                    exp_wr[t + 1 + k]   = 1'b1;
                    exp_idx[t + 1 + k]  = 4'(k);
                    exp_word[t + 1 + k] = base[r] + 16'(k);
                end
                exp_done[fin] = 2'(1 << r);
                exp_err[fin]  = terr ? 2'(1 << r) : 2'b00;
                $display("txn %0d: t=%0d req%0d cnt=%0d type=%h done_at=%0d err=%0d",
                         n_txn, t, r, c, typ[r], fin, terr);
                n_txn++;
                last_srv      = r;
                hold_until[r] = fin;
                free_at       = fin + 1;
            end

            busy = busy_wave[t];
            @(negedge clk);
            check("grant", 32'(grant),   32'(exp_grant[t]));
            check("wr",    32'(wr),      32'(exp_wr[t]));
            check("idx",   32'(widx),    32'(exp_idx[t]));
            check("word",  32'(tx_word), 32'(exp_word[t]));
            check("dv",    32'(dv),      32'(exp_dv[t]));
            check("done",  32'(done),    32'(exp_done[t]));
            check("err",   32'(err),     32'(exp_err[t]));
            if (exp_dv[t]) begin
                check("tx_cnt",  32'(tx_cnt),  32'(exp_cnt[t]));
                check("tx_type", 32'(tx_type), 32'(exp_type[t]));
            end
            @(posedge clk);
            #1;
        end

        // Reset on the second LOAD cycle abandons the packet; a held request restarts at index 0.
        cur_t = -1;
        req = 2'b01; cnt[0] = 4'd5; typ[0] = 4'h3; base[0] = 16'h5000; busy = 1'b0;
        $display("txn %0d: directed reset during load, req0 cnt=5", n_txn);
        @(negedge clk);
        check("dir_pre_grant", 32'(grant), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("dir_grant", 32'(grant), 32'd1);
        check("dir_idx0",  32'(widx),  32'd0);
        check("dir_wr",    32'(wr),    32'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check("dir_idx1",  32'(widx),    32'd1);
        check("dir_word1", 32'(tx_word), 32'h5001);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("dir_rst");
        @(posedge clk); #1;
        @(negedge clk);
        check("dir_regrant", 32'(grant), 32'd1);
        check("dir_restart", 32'(widx),  32'd0);
        check("dir_rewr",    32'(wr),    32'd1);
        check("dir_nodone",  32'(done),  32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
